// File: rtl/rnd_sat.sv
// rtl/rnd_sat.sv - registered right-shift, round and saturate/wrap stage (optional sat_o flag via RND_SAT_FLAG_EN)
package math_pkg;
    typedef enum logic [2:0] {
        DIRECT_DOWN  = 3'd0,
        DIRECT_UP    = 3'd1,
        TO_ZERO      = 3'd2,
        AWAY_ZERO    = 3'd3,
        NEAREST_UP   = 3'd4,
        NEAREST_EVEN = 3'd5
    } round_mode_e;
endpackage

module rnd_sat
    import math_pkg::*;
#(
    parameter int InDw    = 16,
    parameter int OutDw   = 8,
    parameter int ShiftDw = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               tc_mode_i,
    input  round_mode_e        round_mode_i,
    input  logic               saturate_en_i,
    input  logic [ShiftDw-1:0] shift_i,
    input  logic [InDw-1:0]    data_i,
    output logic [OutDw-1:0]   data_o
`ifdef RND_SAT_FLAG_EN
    ,
    output logic               sat_o
`endif
);

    // Output range limits expressed at the internal InDw+1 width
    localparam logic signed [InDw:0] S_MAX = {{(InDw-OutDw+2){1'b0}}, {(OutDw-1){1'b1}}};
    localparam logic signed [InDw:0] S_MIN = {{(InDw-OutDw+2){1'b1}}, {(OutDw-1){1'b0}}};
    localparam logic signed [InDw:0] U_MAX = {{(InDw-OutDw+1){1'b0}}, {OutDw{1'b1}}};
    localparam logic [InDw-1:0]      ONE   = {{(InDw-1){1'b0}}, 1'b1};

    logic signed [InDw:0] ext;
    logic signed [InDw:0] shifted;
    logic signed [InDw:0] rounded;
    logic [InDw-1:0]      frac;
    logic [InDw-1:0]      half;
    logic                 neg;
    logic                 frac_nz;
    logic                 inc;
    logic                 over;
    logic                 under;
    logic [OutDw-1:0]     result;

    always_comb begin
        ext     = tc_mode_i ? {data_i[InDw-1], data_i} : {1'b0, data_i};
        shifted = ext >>> shift_i;
        frac    = data_i & ~({InDw{1'b1}} << shift_i);
        half    = ONE << (shift_i - ShiftDw'(1));
        neg     = tc_mode_i & data_i[InDw-1];
        frac_nz = |frac;
        inc     = 1'b0;
        case (round_mode_i)
            DIRECT_UP:    inc = frac_nz;
            TO_ZERO:      inc = frac_nz & neg;
            AWAY_ZERO:    inc = frac_nz & ~neg;
            NEAREST_UP:   inc = (frac >= half);
            NEAREST_EVEN: inc = (frac > half) | ((frac == half) & shifted[0]);
            default:      inc = 1'b0;
        endcase
        // No discarded bits means nothing to round
        if (shift_i == '0) begin
            inc = 1'b0;
        end
        rounded = shifted + {{InDw{1'b0}}, inc};
        over    = rounded > (tc_mode_i ? S_MAX : U_MAX);
        under   = tc_mode_i & (rounded < S_MIN);
        result  = rounded[OutDw-1:0];
        if (saturate_en_i && over) begin
            result = tc_mode_i ? S_MAX[OutDw-1:0] : U_MAX[OutDw-1:0];
        end else if (saturate_en_i && under) begin
            result = S_MIN[OutDw-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o <= '0;
        end else begin
            data_o <= result;
        end
    end

`ifdef RND_SAT_FLAG_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sat_o <= 1'b0;
        end else begin
            sat_o <= over | under;
        end
    end
`endif

endmodule

// File: tb/tb_rnd_sat.sv
// tb/tb_rnd_sat.sv - self-checking bench for rnd_sat against an arithmetic reference model
module tb_rnd_sat;
    import math_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        tc_mode_i = 1'b0;
    round_mode_e round_mode_i = DIRECT_DOWN;
    logic        saturate_en_i = 1'b0;
    logic [2:0]  shift_i = '0;
    logic [15:0] data_i = '0;
    logic [7:0]  data_o;
`ifdef RND_SAT_FLAG_EN
    logic        sat_o;
`endif

    int checks = 0;
    int errors = 0;

    rnd_sat #(.InDw(16), .OutDw(8), .ShiftDw(3)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .tc_mode_i    (tc_mode_i),
        .round_mode_i (round_mode_i),
        .saturate_en_i(saturate_en_i),
        .shift_i      (shift_i),
        .data_i       (data_i),
        .data_o       (data_o)
`ifdef RND_SAT_FLAG_EN
        ,
        .sat_o        (sat_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Returns {out_of_range, result} from plain integer arithmetic
    function automatic logic [8:0] ref_model(bit tc, int mode, bit sat, int sh, logic [15:0] d);
        longint v, dv, q, f, half, r, lo, hi, res;
        bit inc;
        v  = tc ? longint'($signed(d)) : longint'(d);
        dv = longint'(1) << sh;
        q  = v / dv;
        if ((v % dv) != 0 && v < 0) q = q - 1;
        f    = v - q * dv;
        half = dv / 2;
        inc  = 1'b0;
        if (sh != 0) begin
            case (mode)
                1: inc = (f != 0);
                2: inc = (f != 0) && (v < 0);
                3: inc = (f != 0) && (v >= 0);
                4: inc = (f >= half);
                5: inc = (f > half) || ((f == half) && (q % 2 != 0));
                default: inc = 1'b0;
            endcase
        end
        r  = q + longint'(inc);
        lo = tc ? -128 : 0;
        hi = tc ? 127 : 255;
        res = r;
        if (sat && r > hi) res = hi;
        if (sat && r < lo) res = lo;
        return {(r < lo || r > hi), 8'(res)};
    endfunction

    task automatic drive(input bit tc, input int mode, input bit sat, input int sh, input logic [15:0] d);
        tc_mode_i     = tc;
        round_mode_i  = round_mode_e'(3'(mode));
        saturate_en_i = sat;
        shift_i       = 3'(sh);
        data_i        = d;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if (data_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_initial data_o=%h expected=00", data_o);
        end
        @(posedge clk_i);
        #1;
        checks++;
        if (data_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_held data_o=%h expected=00", data_o);
        end
        rst_i = 1'b0;
    endtask

    task automatic test_unsigned_sat;
        drive(0, 0, 1, 6, 16'h5FA0);
        checks++;
        if (data_o !== 8'hFF) begin
            errors++;
            $display("FAIL unsigned_sat_on data_o=%h expected=ff", data_o);
        end
        drive(0, 0, 0, 6, 16'h5FA0);
        checks++;
        if (data_o !== 8'h7E) begin
            errors++;
            $display("FAIL unsigned_sat_off data_o=%h expected=7e", data_o);
        end
    endtask

    task automatic test_signed_modes;
        logic [7:0] exp_tab [6];
        exp_tab = '{8'hFE, 8'hFF, 8'hFF, 8'hFE, 8'hFF, 8'hFE};
        for (int m = 0; m < 6; m++) begin
            drive(1, m, 1, 6, 16'hFFA0);
            checks++;
            if (data_o !== exp_tab[m]) begin
                errors++;
                $display("FAIL signed_mode%0d data_o=%h expected=%h", m, data_o, exp_tab[m]);
            end
        end
    endtask

    task automatic test_signed_sat;
        logic [15:0] din [4];
        bit          sat [4];
        logic [7:0]  exp_tab [4];
        din     = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000};
        sat     = '{1'b1, 1'b1, 1'b0, 1'b0};
        exp_tab = '{8'h7F, 8'h80, 8'hFF, 8'h00};
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, sat[i], 0, din[i]);
            checks++;
            if (data_o !== exp_tab[i]) begin
                errors++;
                $display("FAIL signed_sat%0d data_o=%h expected=%h", i, data_o, exp_tab[i]);
            end
`ifdef RND_SAT_FLAG_EN
            checks++;
            if (sat_o !== 1'b1) begin
                errors++;
                $display("FAIL signed_sat_flag%0d sat_o=%b expected=1", i, sat_o);
            end
`endif
        end
    endtask

    task automatic test_round_carry;
        drive(0, 1, 1, 7, 16'hFFFF);
        checks++;
        if (data_o !== 8'hFF) begin
            errors++;
            $display("FAIL carry_sat_on data_o=%h expected=ff", data_o);
        end
`ifdef RND_SAT_FLAG_EN
        checks++;
        if (sat_o !== 1'b1) begin
            errors++;
            $display("FAIL carry_flag_on sat_o=%b expected=1", sat_o);
        end
`endif
        drive(0, 1, 0, 7, 16'hFFFF);
        checks++;
        if (data_o !== 8'h00) begin
            errors++;
            $display("FAIL carry_sat_off data_o=%h expected=00", data_o);
        end
`ifdef RND_SAT_FLAG_EN
        checks++;
        if (sat_o !== 1'b1) begin
            errors++;
            $display("FAIL carry_flag_off sat_o=%b expected=1", sat_o);
        end
`endif
    endtask

    task automatic test_nearest_even;
        drive(0, 5, 1, 1, 16'h0005);
        checks++;
        if (data_o !== 8'h02) begin
            errors++;
            $display("FAIL ne_tie_2p5 data_o=%h expected=02", data_o);
        end
        drive(0, 5, 1, 1, 16'h0007);
        checks++;
        if (data_o !== 8'h04) begin
            errors++;
            $display("FAIL ne_tie_3p5 data_o=%h expected=04", data_o);
        end
        drive(0, 6, 1, 1, 16'h0007);
        checks++;
        if (data_o !== 8'h03) begin
            errors++;
            $display("FAIL reserved_mode6 data_o=%h expected=03", data_o);
        end
    endtask

    task automatic test_back_to_back;
        logic [8:0]  exp_v;
        logic [15:0] d;
        bit          tc, sat;
        int          mode, sh;
        for (int i = 0; i < 400; i++) begin
            tc   = 1'($urandom);
            sat  = 1'($urandom);
            mode = int'($urandom_range(0, 7));
            sh   = int'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       d = 16'($urandom_range(0, 511));
                1:       d = 16'hFFFF - 16'($urandom_range(0, 511));
                default: d = 16'($urandom);
            endcase
            exp_v = ref_model(tc, mode, sat, sh, d);
            drive(tc, mode, sat, sh, d);
            checks++;
            if (data_o !== exp_v[7:0]) begin
                errors++;
                $display("FAIL random%0d tc=%0d mode=%0d sat=%0d sh=%0d d=%h data_o=%h expected=%h",
                         i, tc, mode, sat, sh, d, data_o, exp_v[7:0]);
            end
`ifdef RND_SAT_FLAG_EN
            checks++;
            if (sat_o !== exp_v[8]) begin
                errors++;
                $display("FAIL random_flag%0d sat_o=%b expected=%b", i, sat_o, exp_v[8]);
            end
`endif
        end
    endtask

    task automatic test_reset_midrun;
        drive(0, 0, 1, 0, 16'h0055);
        checks++;
        if (data_o !== 8'h55) begin
            errors++;
            $display("FAIL prereset data_o=%h expected=55", data_o);
        end
        #2;
        rst_i = 1'b1;
        #1;
        checks++;
        if (data_o !== 8'h00) begin
            errors++;
            $display("FAIL async_reset data_o=%h expected=00", data_o);
        end
        data_i = 16'h0033;
        @(posedge clk_i);
        #1;
        checks++;
        if (data_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_hold_edge data_o=%h expected=00", data_o);
        end
        #2;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        checks++;
        if (data_o !== 8'h33) begin
            errors++;
            $display("FAIL post_reset data_o=%h expected=33", data_o);
        end
    endtask

    initial begin
        test_reset;
        test_unsigned_sat;
        test_signed_modes;
        test_signed_sat;
        test_round_carry;
        test_nearest_even;
        test_back_to_back;
        test_reset_midrun;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
